// File: rtl/mem_wb_reg.sv
// -----------------------------------------------------------------------------
// mem_wb_reg
//
// Pipeline register between the memory stage and the writeback stage.
// Each cycle it picks the writeback value from the memory-stage results,
// registers it together with the destination index and write enable, and
// presents one valid-qualified writeback bundle to the register file.
//
// Update priority on each rising edge: reset > halted > flush > stall > load.
// A sticky halt flag freezes all state until reset. A saturating 16-bit
// counter tracks retired instructions.
//
// Ports:
//   clk          processor clock, rising-edge active
//   rst          asynchronous active-low reset
//   stall        hold every register
//   flush        load a bubble instead of the incoming bundle (beats stall)
//   valid_in     incoming bundle is a real instruction
//   mem_data_in  data memory read data
//   alu_in       ALU result / memory address
//   pc_in        PC+2 of the instruction (link value)
//   setrd_in     set-instruction condition result
//   regsrc_in    writeback source select (00 mem, 01 alu, 10 pc, 11 setrd)
//   rd_in        destination register index
//   regwrt_in    instruction writes the register file
//   halt_in      instruction is HALT
//   valid_out    registered bundle is a real instruction
//   wb_data      registered writeback value
//   rd_out       registered destination index
//   regwrt_out   register-file write enable, never 1 without valid_out
//   halt_out     sticky halt flag
//   retired      saturating count of retired instructions
// -----------------------------------------------------------------------------
module mem_wb_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        valid_in,
  input  logic [15:0] mem_data_in,
  input  logic [15:0] alu_in,
  input  logic [15:0] pc_in,
  input  logic        setrd_in,
  input  logic [1:0]  regsrc_in,
  input  logic [2:0]  rd_in,
  input  logic        regwrt_in,
  input  logic        halt_in,
  output logic        valid_out,
  output logic [15:0] wb_data,
  output logic [2:0]  rd_out,
  output logic        regwrt_out,
  output logic        halt_out,
  output logic [15:0] retired
);

  localparam logic [1:0]  SRC_MEM  = 2'b00;
  localparam logic [1:0]  SRC_ALU  = 2'b01;
  localparam logic [1:0]  SRC_PC   = 2'b10;
  localparam logic [1:0]  SRC_SET  = 2'b11;
  localparam logic [15:0] RET_MAX  = 16'hFFFF;

  // Writeback source multiplexer.
  function automatic logic [15:0] wb_select(
    input logic [1:0]  sel,
    input logic [15:0] mem_v,
    input logic [15:0] alu_v,
    input logic [15:0] pc_v,
    input logic        set_v
  );
    logic [15:0] res;
    case (sel)
      SRC_MEM: res = mem_v;
      SRC_ALU: res = alu_v;
      SRC_PC:  res = pc_v;
      SRC_SET: res = {15'd0, set_v};
      default: res = 16'h0000;
    endcase
    return res;
  endfunction

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    logic [15:0] res;
    if (v == RET_MAX) begin
      res = RET_MAX;
    end else begin
      res = v + 16'd1;
    end
    return res;
  endfunction

  logic        valid_q,   valid_d;
  logic [15:0] wb_data_q, wb_data_d;
  logic [2:0]  rd_q,      rd_d;
  logic        regwrt_q,  regwrt_d;
  logic        halt_q,    halt_d;
  logic [15:0] retired_q, retired_d;
  logic [15:0] wb_sel_s;

  // Select the writeback value from the unregistered memory-stage results.
  always_comb begin
    wb_sel_s = wb_select(regsrc_in, mem_data_in, alu_in, pc_in, setrd_in);
  end

  // Next-state logic: default is hold, then apply halted > flush > stall > load.
  always_comb begin
    valid_d   = valid_q;
    wb_data_d = wb_data_q;
    rd_d      = rd_q;
    regwrt_d  = regwrt_q;
    halt_d    = halt_q;
    retired_d = retired_q;

    if (halt_q) begin
      // Halted: everything frozen until reset; stall and flush are ignored.
      valid_d = valid_q;
    end else if (flush) begin
      valid_d   = 1'b0;
      wb_data_d = 16'h0000;
      rd_d      = 3'd0;
      regwrt_d  = 1'b0;
    end else if (stall) begin
      valid_d = valid_q;
    end else begin
      valid_d   = valid_in;
      wb_data_d = wb_sel_s;
      rd_d      = rd_in;
      // Gate the write enable so an upstream bubble can never write.
      regwrt_d  = regwrt_in & valid_in;
      if (valid_in) begin
        retired_d = sat_inc(retired_q);
        halt_d    = halt_in;
      end else begin
        retired_d = retired_q;
        halt_d    = halt_q;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      wb_data_q <= 16'h0000;
      rd_q      <= 3'd0;
      regwrt_q  <= 1'b0;
      halt_q    <= 1'b0;
      retired_q <= 16'h0000;
    end else begin
      valid_q   <= valid_d;
      wb_data_q <= wb_data_d;
      rd_q      <= rd_d;
      regwrt_q  <= regwrt_d;
      halt_q    <= halt_d;
      retired_q <= retired_d;
    end
  end

  assign valid_out  = valid_q;
  assign wb_data    = wb_data_q;
  assign rd_out     = rd_q;
  assign regwrt_out = regwrt_q;
  assign halt_out   = halt_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_mem_wb_reg.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_reg
//
// Directed self-checking bench for mem_wb_reg. Each task drives one scenario
// and checks the registered outputs against hand-computed values, sampled
// 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_mem_wb_reg;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        valid_in;
  logic [15:0] mem_data_in;
  logic [15:0] alu_in;
  logic [15:0] pc_in;
  logic        setrd_in;
  logic [1:0]  regsrc_in;
  logic [2:0]  rd_in;
  logic        regwrt_in;
  logic        halt_in;
  logic        valid_out;
  logic [15:0] wb_data;
  logic [2:0]  rd_out;
  logic        regwrt_out;
  logic        halt_out;
  logic [15:0] retired;

  int tests_run;
  int tests_failed;

  mem_wb_reg dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .valid_in    (valid_in),
    .mem_data_in (mem_data_in),
    .alu_in      (alu_in),
    .pc_in       (pc_in),
    .setrd_in    (setrd_in),
    .regsrc_in   (regsrc_in),
    .rd_in       (rd_in),
    .regwrt_in   (regwrt_in),
    .halt_in     (halt_in),
    .valid_out   (valid_out),
    .wb_data     (wb_data),
    .rd_out      (rd_out),
    .regwrt_out  (regwrt_out),
    .halt_out    (halt_out),
    .retired     (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [1:0] src, input logic [2:0] rd,
                       input logic wr, input logic h);
    valid_in    = v;
    regsrc_in   = src;
    rd_in       = rd;
    regwrt_in   = wr;
    halt_in     = h;
    mem_data_in = 16'hBEEF;
    alu_in      = 16'h1234;
    pc_in       = 16'h0042;
    setrd_in    = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst   = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b0, 2'b00, 3'd0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    tests_run++;
    if (valid_out !== 1'b0 || retired !== 16'h0000 || halt_out !== 1'b0) begin
      $display("FAIL reset_init: valid=%b retired=%h halt=%b expected 0 0000 0",
               valid_out, retired, halt_out);
      tests_failed++;
    end
    drive(1'b1, 2'b01, 3'd6, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    tests_run++;
    if (valid_out !== 1'b1 || retired !== 16'd5 || regwrt_out !== 1'b1 ||
        wb_data !== 16'h1234 || rd_out !== 3'd6) begin
      $display("FAIL reset_preload: valid=%b retired=%0d regwrt=%b wb=%h rd=%0d expected 1 5 1 1234 6",
               valid_out, retired, regwrt_out, wb_data, rd_out);
      tests_failed++;
    end
    // Mid-cycle reset, no clock edge in between.
    #3;
    rst = 1'b0;
    #1;
    tests_run++;
    if (valid_out !== 1'b0 || wb_data !== 16'h0000 || rd_out !== 3'd0 ||
        regwrt_out !== 1'b0 || halt_out !== 1'b0 || retired !== 16'h0000) begin
      $display("FAIL reset_async: valid=%b wb=%h rd=%0d regwrt=%b halt=%b retired=%h expected all zero",
               valid_out, wb_data, rd_out, regwrt_out, halt_out, retired);
      tests_failed++;
    end
    #1;
    rst = 1'b1;
    tick();
    tests_run++;
    if (retired !== 16'd1 || valid_out !== 1'b1) begin
      $display("FAIL reset_release: retired=%0d valid=%b expected 1 1", retired, valid_out);
      tests_failed++;
    end
  endtask

  task automatic test_source_select();
    logic [15:0] exp_wb [4];
    exp_wb[0] = 16'hBEEF;
    exp_wb[1] = 16'h1234;
    exp_wb[2] = 16'h0042;
    exp_wb[3] = 16'h0001;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), 3'(i + 1), 1'b1, 1'b0);
      tick();
      tests_run++;
      if (wb_data !== exp_wb[i] || rd_out !== 3'(i + 1) || retired !== 16'(i + 1)) begin
        $display("FAIL src_sel_%0d: wb=%h rd=%0d retired=%0d expected %h %0d %0d",
                 i, wb_data, rd_out, retired, exp_wb[i], i + 1, i + 1);
        tests_failed++;
      end
    end
    // setrd = 0 on select 11 yields zero.
    drive(1'b1, 2'b11, 3'd0, 1'b1, 1'b0);
    setrd_in = 1'b0;
    tick();
    tests_run++;
    if (wb_data !== 16'h0000 || retired !== 16'd5) begin
      $display("FAIL src_setrd0: wb=%h retired=%0d expected 0000 5", wb_data, retired);
      tests_failed++;
    end
  endtask

  task automatic test_stall_flush();
    drive(1'b1, 2'b00, 3'd5, 1'b1, 1'b0);
    tick();
    // retired now 6
    stall = 1'b1;
    drive(1'b1, 2'b01, 3'd2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (rd_out !== 3'd5 || regwrt_out !== 1'b1 || wb_data !== 16'hBEEF ||
          valid_out !== 1'b1 || retired !== 16'd6) begin
        $display("FAIL stall_hold_%0d: rd=%0d regwrt=%b wb=%h valid=%b retired=%0d expected 5 1 beef 1 6",
                 i, rd_out, regwrt_out, wb_data, valid_out, retired);
        tests_failed++;
      end
    end
    flush = 1'b1;
    tick();
    tests_run++;
    if (valid_out !== 1'b0 || regwrt_out !== 1'b0 || wb_data !== 16'h0000 ||
        rd_out !== 3'd0 || retired !== 16'd6) begin
      $display("FAIL stall_flush: valid=%b regwrt=%b wb=%h rd=%0d retired=%0d expected 0 0 0000 0 6",
               valid_out, regwrt_out, wb_data, rd_out, retired);
      tests_failed++;
    end
    stall = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_bubble();
    drive(1'b0, 2'b01, 3'd3, 1'b1, 1'b0);
    tick();
    tests_run++;
    if (valid_out !== 1'b0 || regwrt_out !== 1'b0 || retired !== 16'd6 || rd_out !== 3'd3) begin
      $display("FAIL bubble: valid=%b regwrt=%b retired=%0d rd=%0d expected 0 0 6 3",
               valid_out, regwrt_out, retired, rd_out);
      tests_failed++;
    end
    // A bubble carrying halt_in must not halt.
    drive(1'b0, 2'b01, 3'd3, 1'b1, 1'b1);
    tick();
    tests_run++;
    if (halt_out !== 1'b0 || retired !== 16'd6) begin
      $display("FAIL bubble_halt: halt=%b retired=%0d expected 0 6", halt_out, retired);
      tests_failed++;
    end
  endtask

  task automatic test_back_to_back();
    // valid, regsrc, rd, regwrt -> expected wb, regwrt_out, retired
    logic        v_t   [4];
    logic [1:0]  s_t   [4];
    logic [15:0] wb_t  [4];
    logic [15:0] ret_t [4];
    v_t[0] = 1'b1; s_t[0] = 2'b10; wb_t[0] = 16'h0042; ret_t[0] = 16'd7;
    v_t[1] = 1'b0; s_t[1] = 2'b00; wb_t[1] = 16'hBEEF; ret_t[1] = 16'd7;
    v_t[2] = 1'b1; s_t[2] = 2'b11; wb_t[2] = 16'h0001; ret_t[2] = 16'd8;
    v_t[3] = 1'b1; s_t[3] = 2'b01; wb_t[3] = 16'h1234; ret_t[3] = 16'd9;
    for (int i = 0; i < 4; i++) begin
      drive(v_t[i], s_t[i], 3'(7 - i), 1'b1, 1'b0);
      tick();
      tests_run++;
      if (valid_out !== v_t[i] || wb_data !== wb_t[i] || regwrt_out !== v_t[i] ||
          retired !== ret_t[i] || rd_out !== 3'(7 - i)) begin
        $display("FAIL b2b_%0d: valid=%b wb=%h regwrt=%b retired=%0d rd=%0d expected %b %h %b %0d %0d",
                 i, valid_out, wb_data, regwrt_out, retired, rd_out,
                 v_t[i], wb_t[i], v_t[i], ret_t[i], 7 - i);
        tests_failed++;
      end
    end
  endtask

  task automatic test_halt();
    drive(1'b1, 2'b01, 3'd4, 1'b1, 1'b1);
    alu_in = 16'h7777;
    tick();
    tests_run++;
    if (halt_out !== 1'b1 || retired !== 16'd10 || wb_data !== 16'h7777 ||
        valid_out !== 1'b1 || rd_out !== 3'd4 || regwrt_out !== 1'b1) begin
      $display("FAIL halt_set: halt=%b retired=%0d wb=%h valid=%b rd=%0d regwrt=%b expected 1 10 7777 1 4 1",
               halt_out, retired, wb_data, valid_out, rd_out, regwrt_out);
      tests_failed++;
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b00, 3'd1, 1'b0, 1'b0);
      flush = (i == 1);
      stall = (i == 2);
      tick();
      tests_run++;
      if (halt_out !== 1'b1 || retired !== 16'd10 || wb_data !== 16'h7777 ||
          valid_out !== 1'b1 || rd_out !== 3'd4 || regwrt_out !== 1'b1) begin
        $display("FAIL halt_frozen_%0d: halt=%b retired=%0d wb=%h valid=%b rd=%0d regwrt=%b expected 1 10 7777 1 4 1",
                 i, halt_out, retired, wb_data, valid_out, rd_out, regwrt_out);
        tests_failed++;
      end
    end
    flush = 1'b0;
    stall = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    tests_run++;
    if (halt_out !== 1'b0 || retired !== 16'h0000 || valid_out !== 1'b0) begin
      $display("FAIL halt_clear: halt=%b retired=%h valid=%b expected 0 0000 0",
               halt_out, retired, valid_out);
      tests_failed++;
    end
    rst = 1'b1;
  endtask

  task automatic test_saturation();
    apply_reset();
    drive(1'b1, 2'b01, 3'd1, 1'b1, 1'b0);
    for (int i = 0; i < 65534; i++) begin
      @(posedge clk);
    end
    #1;
    tests_run++;
    if (retired !== 16'hFFFE) begin
      $display("FAIL sat_preload: retired=%h expected fffe", retired);
      tests_failed++;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (retired !== 16'hFFFF) begin
        $display("FAIL sat_%0d: retired=%h expected ffff", i, retired);
        tests_failed++;
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst   = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b0, 2'b00, 3'd0, 1'b0, 1'b0);
    test_reset();
    test_source_select();
    test_stall_flush();
    test_bubble();
    test_back_to_back();
    test_halt();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
